data_sram_like_bridge: RTL
==========================

Name: data_sram_like_bridge

Overview:
Converts the core's single-cycle, SRAM-style data-memory access from the MEM stage into the sram_like request/response handshake used by the AXI bridge (data_req/addr_ok/data_ok). It generates the dataStall signal consumed by the pipeline's hazard unit. It holds the returned read data stable until the whole pipeline is released (longest_stall low), so a load is never lost while another stall source is active. It sits directly between the datapath MEM stage and the sram_like-to-AXI converter.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte lanes = DATA_W/8 = 4)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
data_sram_en  in  1  MEM-stage access valid (already gated by address-error checks)
data_sram_wen  in  1  1 = store, 0 = load
data_sram_sel  in  4  byte-lane enables: 0001/0010/0100/1000, 0011/1100, or 1111
data_sram_addr  in  ADDR_W  byte address
data_sram_wdata  in  DATA_W  store data, already lane-aligned
data_sram_rdata  out  DATA_W  load data returned to the MEM stage
longest_stall  in  1  OR of all pipeline stall sources, from the hazard unit
d_stall  out  1  dataStall to the hazard unit
data_req  out  1  sram_like request
data_wr  out  1  sram_like write flag
data_size  out  2  0 = byte, 1 = half, 2 = word
data_addr  out  ADDR_W  sram_like address
data_wdata  out  DATA_W  sram_like write data
data_addr_ok  in  1  address phase accepted
data_rdata  in  DATA_W  sram_like read data
data_data_ok  in  1  data phase complete

Behaviour:
- FSM states: IDLE, ADDR, DATA, DONE. Reset value is IDLE. rdata_buf resets to 0.
- data_req = (IDLE & data_sram_en) | ADDR. The request is combinational in IDLE, which gives zero-bubble issue.
- data_wr, data_addr and data_wdata pass straight through from the data_sram_* inputs. The MEM stage is frozen while d_stall is high, so these stay stable.
- data_size is decoded from data_sram_sel: 1111 gives 2; 0011 or 1100 gives 1; a one-hot value gives 0. Any other pattern gives 2 and is flagged by a simulation assertion.
- Transitions:
  - IDLE: en & addr_ok goes to DATA. en & ~addr_ok goes to ADDR. ~en stays in IDLE.
  - ADDR: addr_ok goes to DATA, otherwise stay (request held).
  - DATA: data_ok latches data_rdata into rdata_buf and goes to DONE.
  - DONE: ~longest_stall goes to IDLE, otherwise stay.
- data_data_ok is never accepted in the same cycle as data_addr_ok for the same request. data_ok seen outside DATA is ignored, and a simulation assertion fires.
- d_stall = data_sram_en & (state != DONE). It is 0 whenever en is 0.
- data_sram_rdata = rdata_buf. It is valid in DONE and stays stable until the next data_ok.
- Stores: the same FSM path is used; data_rdata is captured but ignored by the core.
- Minimum latency for an access:
  - Request issued in cycle 0.
  - If addr_ok arrives in cycle 0 and data_ok in cycle 1, the FSM is in DONE in cycle 2.
  - d_stall is high for cycles 0–1 and low in cycle 2.
- Once addr_ok is accepted, a transaction cannot be cancelled. It always runs to DONE, even if data_sram_en drops. In that case DONE exits to IDLE on the first ~longest_stall.
- If data_sram_en drops while in ADDR, the request is withdrawn (data_req goes to 0) and the FSM returns to IDLE. This is legal only because addr_ok was not yet seen.
- Reset mid-transaction: the FSM goes to IDLE and data_req is 0 immediately (asynchronous). The downstream bridge is reset by the same rst.
- Back-to-back accesses: DONE to IDLE takes one cycle, and the next MEM instruction requests in that IDLE cycle.

Decomposition:
- Shared package (alongside defines2.vh): FSM state encodings (2-bit), size constants SIZE_BYTE/SIZE_HALF/SIZE_WORD.
- One natural sub-module: sel_to_size, the combinational sel[3:0] to size[1:0] decoder. It is reused by the instruction-side bridge, which has constant 1111.

Test Plan:
- Load word, addr 0x1000, sel 1111: addr_ok in cycle 0, data_ok with 0xDEADBEEF in cycle 1 → data_req=1, data_size=2, data_wr=0 in cycle 0; d_stall=1 in cycles 0–1, 0 in cycle 2; rdata=0xDEADBEEF.
- Store byte, addr 0x1003, sel 1000, wdata 0xAB000000: addr_ok delayed 3 cycles → data_req held for 4 cycles with a stable address; data_size=0, data_wr=1; d_stall falls one cycle after data_ok.
- Load completes while longest_stall=1 for 5 extra cycles → FSM stays in DONE; rdata stays at the captured value while data_rdata changes; d_stall=0; no new data_req until one cycle after longest_stall falls.
- Two consecutive loads (sel 0011 at 0x2000, then 1111 at 0x2004) → sizes 1 then 2; second data_req appears in the IDLE cycle right after DONE exits; no duplicate requests.
- rst asserted in DATA state → data_req=0, d_stall follows en with state IDLE, rdata=0 asynchronously; after release, a fresh load completes normally.
- data_sram_en=0 for 10 cycles with spurious data_ok pulses → data_req=0, d_stall=0, rdata unchanged.

Source files
------------

// File: rtl/data_sram_like_bridge_pkg.sv
// Shared types for the data-side sram_like bridge: FSM state encoding, transfer
// size codes and the legal byte-lane pattern check.
package data_sram_like_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic logic sel_is_legal(input logic [3:0] sel);
    case (sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: sel_is_legal = 1'b1;
      default:                   sel_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_sram_like_bridge_if.sv
// sram_like request/response bus between the core-side bridge (master) and the
// sram_like-to-AXI converter (slave).
interface data_sram_like_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic [DATA_W-1:0] data_rdata;
  logic              data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_rdata, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_rdata, data_data_ok
  );
endinterface

// File: rtl/data_sram_like_bridge_sel_to_size.sv
// Byte-lane enable to sram_like size decoder; purely combinational.
// Illegal lane patterns fall back to a word transfer.
module data_sram_like_bridge_sel_to_size
  import data_sram_like_bridge_pkg::*;
(
  input  logic [3:0] sel,
  output logic [1:0] size
);

  always_comb begin
    size = SIZE_WORD;
    case (sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
      4'b0011, 4'b1100:                   size = SIZE_HALF;
      default:                            size = SIZE_WORD;
    endcase
  end

endmodule

// File: rtl/data_sram_like_bridge.sv
// MEM-stage SRAM access to sram_like handshake; request issues combinationally in
// IDLE, best case 2 cycles of d_stall, load data held in DONE until the pipeline releases.
module data_sram_like_bridge
  import data_sram_like_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   data_sram_en,
  input  logic                   data_sram_wen,
  input  logic [DATA_W/8-1:0]    data_sram_sel,
  input  logic [ADDR_W-1:0]      data_sram_addr,
  input  logic [DATA_W-1:0]      data_sram_wdata,
  output logic [DATA_W-1:0]      data_sram_rdata,
  input  logic                   longest_stall,
  output logic                   d_stall,
  data_sram_like_bridge_if.master bus
);

  state_t            state;
  logic [DATA_W-1:0] rdata_buf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rdata_buf <= '0;
    end else begin
      case (state)
        ST_IDLE: if (data_sram_en) state <= bus.data_addr_ok ? ST_DATA : ST_ADDR;
        // No address accepted yet, so a vanished MEM access may simply be dropped.
        ST_ADDR: begin
          if (!data_sram_en)         state <= ST_IDLE;
          else if (bus.data_addr_ok) state <= ST_DATA;
        end
        ST_DATA: begin
          if (bus.data_data_ok) begin
            rdata_buf <= bus.data_rdata;
            state     <= ST_DONE;
          end
        end
        ST_DONE: if (!longest_stall) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.data_req   = !rst && data_sram_en && (state == ST_IDLE || state == ST_ADDR);
  assign bus.data_wr    = data_sram_wen;
  assign bus.data_addr  = data_sram_addr;
  assign bus.data_wdata = data_sram_wdata;

  data_sram_like_bridge_sel_to_size u_sel_to_size (
    .sel  (data_sram_sel),
    .size (bus.data_size)
  );

  assign d_stall         = data_sram_en && (state != ST_DONE);
  assign data_sram_rdata = rdata_buf;

  // data_ok pulses while the MEM stage is idle are tolerated and ignored.
  a_data_ok_in_data: assert property (@(posedge clk) disable iff (rst)
    (bus.data_data_ok && data_sram_en) |-> (state == ST_DATA));

  a_sel_legal: assert property (@(posedge clk) disable iff (rst)
    data_sram_en |-> sel_is_legal(data_sram_sel));

endmodule
